// File: rtl/traffic_safety_guard_pkg.sv
// Shared codes, state enumeration and fault-cause constants for the traffic safety guard.
// Build option TRAFFIC_GUARD_SEQ_CHECK_EN (see traffic_guard_checker) changes no item here.
package traffic_safety_guard_pkg;

    localparam logic [3:0] CAR_RED    = 4'b1000;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_LEFT   = 4'b0010;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;
    localparam logic [3:0] CAR_NONE   = 4'b0000;

    localparam logic [1:0] WALK_RED   = 2'b10;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_NONE  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_ILLEGAL  = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_SEQUENCE = 3'd3;
    localparam logic [2:0] FC_TIMEOUT  = 3'd4;

endpackage

// File: rtl/traffic_guard_checker.sv
// Combinational encoding, conflict and phase-order checks on one car/walker sample.
// The phase-order check exists only when TRAFFIC_GUARD_SEQ_CHECK_EN is defined.
module traffic_guard_checker
    import traffic_safety_guard_pkg::*;
(
    input  logic [3:0] i_car,
    input  logic [1:0] i_walker,
`ifdef TRAFFIC_GUARD_SEQ_CHECK_EN
    input  logic [3:0] i_prev_car,
    input  logic [3:0] i_last_ny,
`endif
    output logic       o_fault_valid,
    output logic [2:0] o_fault_code
);

    logic w_car_legal;
    logic w_illegal;
    logic w_conflict;
    logic w_seq_bad;

    assign w_car_legal = i_car inside {CAR_RED, CAR_YELLOW, CAR_LEFT, CAR_GREEN, CAR_NONE};
    assign w_illegal   = !w_car_legal || (i_walker == 2'b11) ||
                         ((i_car == CAR_NONE) && (i_walker != WALK_NONE));
    assign w_conflict  = (i_walker == WALK_GREEN) && (i_car != CAR_RED);

`ifdef TRAFFIC_GUARD_SEQ_CHECK_EN
    logic w_seq_ok;

    // YELLOW is ambiguous on its own; the last non-yellow phase says which way it leads.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_seq_ok = 1'b0;
        if ((i_car == i_prev_car) || (i_car == CAR_NONE)) begin
            w_seq_ok = 1'b1;
        end else begin
            case (i_prev_car)
                CAR_NONE:   w_seq_ok = (i_car == CAR_GREEN);
                CAR_GREEN:  w_seq_ok = (i_car == CAR_YELLOW);
                CAR_YELLOW: w_seq_ok = ((i_car == CAR_LEFT) && (i_last_ny == CAR_GREEN)) ||
                                       ((i_car == CAR_RED)  && (i_last_ny == CAR_LEFT));
                CAR_LEFT:   w_seq_ok = (i_car == CAR_YELLOW);
                CAR_RED:    w_seq_ok = (i_car == CAR_GREEN);
                default:    w_seq_ok = 1'b0;
            endcase
        end
    end

    assign w_seq_bad = !w_seq_ok;
`else
    assign w_seq_bad = 1'b0;
`endif

    always_comb begin
        o_fault_valid = 1'b1;
        o_fault_code  = FC_NONE;
        if (w_illegal) begin
            o_fault_code = FC_ILLEGAL;
        end else if (w_conflict) begin
            o_fault_code = FC_CONFLICT;
        end else if (w_seq_bad) begin
            o_fault_code = FC_SEQUENCE;
        end else begin
            o_fault_valid = 1'b0;
        end
    end

endmodule

// File: rtl/traffic_safety_guard.sv
// Safety stage between the intersection sequencer and lamp drivers: registered pass-through,
// latched fault with flashing-red fail-safe. Build macro: TRAFFIC_GUARD_SEQ_CHECK_EN.
module traffic_safety_guard
    import traffic_safety_guard_pkg::*;
#(
    parameter int MAX_HOLD     = 40,
    parameter int BLINK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] i_car_traffic,
    input  logic [1:0] i_walker_traffic,
    input  logic       i_fault_clr,
    output logic [3:0] o_car_lamp,
    output logic [1:0] o_walker_lamp,
    output logic       o_fault,
    output logic [2:0] o_fault_code
);

    localparam int HOLD_W  = $clog2(MAX_HOLD + 2);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_SAT  = HOLD_W'(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(MAX_HOLD);
    localparam logic [BLINK_W-1:0] BLINK_END = BLINK_W'(BLINK_CYCLES - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [3:0]          r_prev_car;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_next;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic [3:0]          r_car_lamp;
    logic [1:0]          r_walker_lamp;
    logic                r_fault;
    logic [2:0]          r_fault_code;
    logic                w_chk_valid;
    logic [2:0]          w_chk_code;
    logic                w_timeout;
    logic                w_fault_any;
    logic [2:0]          w_fault_code;
    logic                w_clear;
`ifdef TRAFFIC_GUARD_SEQ_CHECK_EN
    logic [3:0]          r_last_ny;
`endif

    traffic_guard_checker u_checker (
        .i_car         (i_car_traffic),
        .i_walker      (i_walker_traffic),
`ifdef TRAFFIC_GUARD_SEQ_CHECK_EN
        .i_prev_car    (r_prev_car),
        .i_last_ny     (r_last_ny),
`endif
        .o_fault_valid (w_chk_valid),
        .o_fault_code  (w_chk_code)
    );

    // The timeout compares the value the hold counter is about to take.
    always_comb begin
        w_hold_next = '0;
        if ((i_car_traffic == r_prev_car) && (i_car_traffic != CAR_NONE)) begin
            w_hold_next = (r_hold_cnt == HOLD_SAT) ? r_hold_cnt : r_hold_cnt + 1'b1;
        end
    end

    assign w_timeout    = (w_hold_next == HOLD_LIM);
    assign w_fault_any  = w_chk_valid || w_timeout;
    assign w_fault_code = w_chk_valid ? w_chk_code : FC_TIMEOUT;
    assign w_clear      = i_fault_clr && (i_car_traffic == CAR_NONE) &&
                          (i_walker_traffic == WALK_NONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fault_any)                        w_state_next = ST_FAULT;
                else if (i_car_traffic != CAR_NONE)     w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_fault_any)                        w_state_next = ST_FAULT;
                else if ((i_car_traffic == CAR_NONE) &&
                         (i_walker_traffic == WALK_NONE)) w_state_next = ST_IDLE;
            end
            ST_FAULT: begin
                if (w_clear)                            w_state_next = ST_IDLE;
            end
            default:                                    w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignment, and the async reset clears every register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_prev_car    <= CAR_NONE;
            r_hold_cnt    <= '0;
            r_blink_cnt   <= '0;
            r_car_lamp    <= CAR_NONE;
            r_walker_lamp <= WALK_NONE;
            r_fault       <= 1'b0;
            r_fault_code  <= FC_NONE;
        end else begin
            r_state    <= w_state_next;
            r_prev_car <= i_car_traffic;
            r_hold_cnt <= w_hold_next;
            if (w_state_next == ST_FAULT) begin
                r_walker_lamp <= WALK_NONE;
                r_fault       <= 1'b1;
                if (r_state != ST_FAULT) begin
                    // Faulting sample is replaced by the first red of the flash.
                    r_car_lamp   <= CAR_RED;
                    r_fault_code <= w_fault_code;
                    r_blink_cnt  <= '0;
                end else if (r_blink_cnt == BLINK_END) begin
                    r_car_lamp  <= (r_car_lamp == CAR_RED) ? CAR_NONE : CAR_RED;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end else begin
                r_car_lamp    <= i_car_traffic;
                r_walker_lamp <= i_walker_traffic;
                r_fault       <= 1'b0;
                r_fault_code  <= FC_NONE;
                r_blink_cnt   <= '0;
            end
        end
    end

`ifdef TRAFFIC_GUARD_SEQ_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_ny <= CAR_NONE;
        end else if (i_car_traffic != CAR_YELLOW) begin
            r_last_ny <= i_car_traffic;
        end
    end
`endif

    assign o_car_lamp    = r_car_lamp;
    assign o_walker_lamp = r_walker_lamp;
    assign o_fault       = r_fault;
    assign o_fault_code  = r_fault_code;

endmodule
